// File: rtl/chip8_pkg.sv
// Shared CHIP-8 memory definitions: the built-in hex font image, default layout
// constants and the memory controller state encoding.
package chip8_pkg;

  localparam int unsigned FONT_BYTES        = 80;
  localparam int unsigned DEFAULT_FONT_BASE = 'h050;
  localparam int unsigned DEFAULT_PROT_TOP  = 'h200;

  typedef enum logic {StInit = 1'b0, StRun = 1'b1} state_e;

  // Glyphs 0..F, five rows each, bit 7 is the leftmost pixel.
  localparam logic [7:0] FONT_ROM [FONT_BYTES] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  function automatic logic [7:0] font_byte(input logic [6:0] idx);
    return FONT_ROM[idx];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first eligible requester at or after the
// pointer, then moves the pointer just past the winner.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_eligible,
  output logic [N-1:0] o_grant_onehot,
  output logic         o_grant_valid
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] r_ptr;
  logic [PtrW-1:0] w_ptr_d;
  logic [N-1:0]    w_rot;
  logic [N-1:0]    w_grant;
  logic            w_valid;

  // Rotate so bit 0 is the port at the pointer; first set bit wins.
  assign w_rot = N'({i_eligible, i_eligible} >> r_ptr);

  always_comb begin
    w_grant = '0;
    w_valid = 1'b0;
    w_ptr_d = r_ptr;
    for (int unsigned j = 0; j < N; j++) begin
      if (!w_valid && w_rot[j]) begin
        w_valid = 1'b1;
        for (int unsigned k = 0; k < N; k++) begin
          if (((32'(r_ptr) + j) % N) == k) begin
            w_grant[k] = 1'b1;
            w_ptr_d    = PtrW'((k + 1) % N);
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (w_valid) begin
      r_ptr <= w_ptr_d;
    end
  end

  assign o_grant_onehot = w_grant;
  assign o_grant_valid  = w_valid;

endmodule

// File: rtl/chip8_mem_arb.sv
// Multi-port CHIP-8 main memory: single-port RAM shared round-robin between
// request channels, self-initialised with zeros and the hex font after reset.
module chip8_mem_arb
  import chip8_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned FONT_BASE = DEFAULT_FONT_BASE,
  parameter int unsigned PROT_TOP  = DEFAULT_PROT_TOP
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  output logic                          o_ready,
  input  logic [NUM_PORTS-1:0]          i_req,
  input  logic [NUM_PORTS-1:0]          i_we,
  input  logic [NUM_PORTS*ADDR_W-1:0]   i_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   i_wdata,
  output logic [NUM_PORTS*DATA_W-1:0]   o_rdata,
  output logic [NUM_PORTS-1:0]          o_ack,
  output logic [NUM_PORTS-1:0]          o_werr
);

  localparam int unsigned       DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e                       r_state;
  logic [ADDR_W-1:0]            r_cnt;
  logic                         r_ready;
  logic [NUM_PORTS-1:0]         r_ack;
  logic [NUM_PORTS-1:0]         r_werr;
  logic [NUM_PORTS*DATA_W-1:0]  r_rdata;
  logic [DATA_W-1:0]            r_mem [DEPTH];

  logic [NUM_PORTS-1:0] w_elig;
  logic [NUM_PORTS-1:0] w_grant;
  logic                 w_grant_valid;
  logic                 w_sel_we;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [DATA_W-1:0]    w_sel_wdata;
  logic                 w_prot;
  logic                 w_in_font;
  logic [DATA_W-1:0]    w_init_data;
  logic                 w_mem_we;
  logic [ADDR_W-1:0]    w_mem_addr;
  logic [DATA_W-1:0]    w_mem_wdata;

  // A port acked this cycle is masked so a still-high req is not served twice.
  assign w_elig = i_req & ~r_ack & {NUM_PORTS{r_state == StRun}};

  rr_arbiter #(
    .N (NUM_PORTS)
  ) u_arb (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_eligible     (w_elig),
    .o_grant_onehot (w_grant),
    .o_grant_valid  (w_grant_valid)
  );

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_grant[p]) begin
        w_sel_we    = i_we[p];
        w_sel_addr  = i_addr[p*ADDR_W +: ADDR_W];
        w_sel_wdata = i_wdata[p*DATA_W +: DATA_W];
      end
    end
  end

  assign w_prot      = 32'(w_sel_addr) < PROT_TOP;
  assign w_in_font   = (32'(r_cnt) >= FONT_BASE) && (32'(r_cnt) < FONT_BASE + FONT_BYTES);
  assign w_init_data = w_in_font ? DATA_W'(font_byte(7'(32'(r_cnt) - FONT_BASE))) : '0;

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = w_sel_addr;
    w_mem_wdata = w_sel_wdata;
    if (r_state == StInit) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_cnt;
      w_mem_wdata = w_init_data;
    end else if (w_grant_valid && w_sel_we && !w_prot) begin
      w_mem_we = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StInit;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_ack   <= '0;
      r_werr  <= '0;
      r_rdata <= '0;
    end else begin
      r_ack  <= '0;
      r_werr <= '0;
      unique case (r_state)
        StInit: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LastAddr) begin
            r_state <= StRun;
            r_ready <= 1'b1;
          end
        end
        StRun: begin
          if (w_grant_valid) begin
            r_ack <= w_grant;
            for (int p = 0; p < NUM_PORTS; p++) begin
              if (w_grant[p]) begin
                if (w_sel_we) begin
                  r_werr[p] <= w_prot;
                end else begin
                  r_rdata[p*DATA_W +: DATA_W] <= r_mem[w_sel_addr];
                end
              end
            end
          end
        end
        default: r_state <= StInit;
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_ack   = r_ack;
  assign o_werr  = r_werr;
  assign o_rdata = r_rdata;

endmodule

// File: tb/tb_chip8_mem_arb.sv
// Scoreboard bench for chip8_mem_arb: drivers push expected responses from a
// byte-array memory model, a monitor pops and compares on every ack.
module tb_chip8_mem_arb;

  localparam int NP = 2;
  localparam int AW = 12;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ready;
  logic [NP-1:0]     req = '0;
  logic [NP-1:0]     we = '0;
  logic [NP*AW-1:0]  addr = '0;
  logic [NP*DW-1:0]  wdata = '0;
  logic [NP*DW-1:0]  rdata;
  logic [NP-1:0]     ack;
  logic [NP-1:0]     werr;

  always #5 clk = ~clk;

  chip8_mem_arb #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .NUM_PORTS (NP),
    .FONT_BASE ('h050),
    .PROT_TOP  ('h200)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .o_ready (ready),
    .i_req   (req),
    .i_we    (we),
    .i_addr  (addr),
    .i_wdata (wdata),
    .o_rdata (rdata),
    .o_ack   (ack),
    .o_werr  (werr)
  );

  typedef struct packed {
    logic          is_wr;
    logic          werr;
    logic [7:0]    rdata;
    logic [AW-1:0] addr;
  } exp_t;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [7:0] model [4096];
  exp_t       q0[$];
  exp_t       q1[$];

  logic [7:0] font [80] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic model_init();
    for (int i = 0; i < 4096; i++) model[i] = 8'h00;
    for (int i = 0; i < 80; i++) model['h50 + i] = font[i];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one request on port p (called at posedge+1), hold until acked.
  task automatic do_op(input int p, input bit w, input logic [AW-1:0] a, input logic [7:0] d,
                       output int lat, output int ack_cyc);
    exp_t e;
    e.is_wr = w;
    e.addr  = a;
    e.werr  = w && (a < 12'h200);
    e.rdata = model[a];
    if (w && a >= 12'h200) model[a] = d;
    if (p == 0) q0.push_back(e);
    else q1.push_back(e);
    addr[p*AW +: AW]  = a;
    wdata[p*DW +: DW] = d;
    we[p]  = w;
    req[p] = 1'b1;
    lat     = 0;
    ack_cyc = -1;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (ack[p]) begin
        ack_cyc = cyc;
        break;
      end
      if (lat >= 20) begin
        tests++;
        fails++;
        $display("FAIL ack_timeout port %0d addr %0h: got no ack expected ack", p, a);
        break;
      end
    end
    req[p] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic rand_port(input int p);
    logic [AW-1:0] a;
    int lat, ac;
    for (int k = 0; k < 200; k++) begin
      a    = AW'($urandom_range(0, 4095));
      a[0] = p[0];
      do_op(p, 1'($urandom_range(0, 1)), a, 8'($urandom), lat, ac);
      idle($urandom_range(0, 2));
    end
  endtask

  // Monitor: every ack is matched against the oldest expectation of its port.
  initial begin
    logic [NP-1:0] prev;
    exp_t e;
    bit have;
    prev = '0;
    forever begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        if (ack[p]) begin
          chk($sformatf("back_to_back_ack_p%0d", p), 32'(prev[p]), 0);
          have = (p == 0) ? (q0.size() != 0) : (q1.size() != 0);
          if (!have) begin
            chk($sformatf("unexpected_ack_p%0d", p), 32'(ack[p]), 0);
          end else begin
            if (p == 0) e = q0.pop_front();
            else e = q1.pop_front();
            chk($sformatf("werr_p%0d_a%0h", p, e.addr), 32'(werr[p]), 32'(e.werr));
            if (!e.is_wr)
              chk($sformatf("rdata_p%0d_a%0h", p, e.addr), 32'(rdata[p*DW +: DW]),
                  32'(e.rdata));
          end
        end
      end
      prev = ack;
    end
  end

  initial begin
    int n, lat, ac0, ac1;
    model_init();
    #1;
    chk("reset_ready", 32'(ready), 0);
    chk("reset_ack", 32'(ack), 0);
    chk("reset_werr", 32'(werr), 0);
    chk("reset_rdata", 32'(rdata), 0);

    // Init sequence and font/zero readback
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n);
    chk("ready_cycle", n, 4096);
    do_op(0, 1'b0, 12'h050, 8'h00, lat, ac0);
    do_op(0, 1'b0, 12'h09F, 8'h00, lat, ac0);
    do_op(0, 1'b0, 12'h000, 8'h00, lat, ac0);
    do_op(1, 1'b0, 12'hFFF, 8'h00, lat, ac0);
    idle(1);

    // Port 0 fill of the unprotected area, then readback
    for (int a = 'h200; a < 4096; a++) begin
      do_op(0, 1'b1, AW'(a), 8'(a % 255), lat, ac0);
      chk("wr_latency", lat, 1);
      idle(1);
    end
    for (int a = 'h200; a < 4096; a++) begin
      do_op(0, 1'b0, AW'(a), 8'h00, lat, ac0);
      chk("rd_latency", lat, 1);
      idle(1);
    end

    // Protected write is dropped
    do_op(1, 1'b1, 12'h100, 8'hAB, lat, ac0);
    idle(1);
    do_op(1, 1'b0, 12'h100, 8'h00, lat, ac0);
    idle(1);

    // Simultaneous requests: pointer now at port 0
    fork
      do_op(0, 1'b0, 12'h300, 8'h00, lat, ac0);
      do_op(1, 1'b0, 12'h301, 8'h00, n, ac1);
    join
    chk("rr_p0_then_p1", ac1 - ac0, 1);
    idle(1);
    do_op(0, 1'b0, 12'h302, 8'h00, lat, ac0);
    idle(1);
    fork
      do_op(0, 1'b0, 12'h300, 8'h00, lat, ac0);
      do_op(1, 1'b0, 12'h301, 8'h00, n, ac1);
    join
    chk("rr_p1_then_p0", ac0 - ac1, 1);
    idle(1);

    // Read on port 1 right after a write on port 0 sees the new data
    fork
      do_op(0, 1'b1, 12'h400, 8'h5A, lat, ac0);
      begin
        idle(1);
        do_op(1, 1'b0, 12'h400, 8'h00, n, ac1);
      end
    join
    chk("raw_read_latency", n, 1);
    idle(2);

    // Randomised concurrent traffic, each port owning one address parity
    fork
      rand_port(0);
      rand_port(1);
    join
    idle(3);
    chk("sb_drain", q0.size() + q1.size(), 0);

    // Reset in the grant cycle of a read: no ack, memory re-initialised
    addr[0 +: AW] = 12'h050;
    we[0]  = 1'b0;
    req[0] = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_ready", 32'(ready), 0);
    chk("midreset_ack", 32'(ack), 0);
    @(posedge clk);
    #1;
    chk("midreset_ack_hold", 32'(ack), 0);
    req[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_init();
    wait_ready(n);
    chk("ready_cycle_rerun", n, 4096);
    do_op(1, 1'b0, 12'h400, 8'h00, lat, ac0);
    do_op(0, 1'b0, 12'h050, 8'h00, lat, ac0);
    do_op(1, 1'b0, 12'h09F, 8'h00, lat, ac0);
    idle(3);
    chk("sb_drain_final", q0.size() + q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
